// File: rtl/popcnt_chunk_seq.sv
// popcnt_chunk_seq
//   Multi-cycle bit-count sequencer. A WIDTH-bit operand is latched on an
//   accepted start, optionally inverted (zero count), zero-padded to a whole
//   number of CHUNK-bit slices and presented one slice per cycle on slice_o
//   to an external combinational counter stage. The counts returned on cnt_i
//   are accumulated and the total is published on result with a done pulse.
//
// Ports
//   clk      in   1       rising-edge clock
//   reset    in   1       asynchronous reset, active low
//   start    in   1       count request, honoured in IDLE or DONE only
//   mode     in   1       0 = count ones, 1 = count zeros
//   operand  in   WIDTH   value to count, latched when start is accepted
//   abort    in   1       synchronous cancel of a running count
//   slice_o  out  CHUNK   current slice for the counter stage (0 when not running)
//   cnt_i    in   3       counter-stage result for slice_o, same cycle
//   busy     out  1       high while counting
//   done     out  1       one-cycle pulse, result valid
//   result   out  CW      last completed count, held until the next completes
module popcnt_chunk_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  input  logic [WIDTH-1:0]             operand,
  input  logic                         abort,
  output logic [CHUNK-1:0]             slice_o,
  input  logic [2:0]                   cnt_i,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   result
);

  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     result_q, result_d;
  logic [PW-1:0]     opnd_q, opnd_d;
  logic [PW-1:0]     prep;
  logic [CW-1:0]     sum;

  // Operand preparation: inversion happens first and padding afterwards, so
  // the pad bits stay zero and never count in either mode. Storing the
  // prepared value means mode needs no register of its own.
  always_comb begin
    prep = '0;
    prep[WIDTH-1:0] = mode ? ~operand : operand;
  end

  // Running total including the slice currently on the counter stage;
  // wraps modulo 2^CW if the counter stage misbehaves.
  assign sum = acc_q + CW'(cnt_i);

  // Sequencer next-state logic. Abort is tested before the final-slice
  // check so a cancel on the last cycle still suppresses the result.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    opnd_d   = opnd_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opnd_d  = prep;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = sum;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDXW'(NCHUNK - 1)) begin
            result_d = sum;
            idx_d    = '0;
            state_d  = DONE;
          end
        end
      end
      default: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      opnd_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      opnd_q   <= opnd_d;
    end
  end

  // Outputs decode straight from registered state; slice is forced to zero
  // outside RUN so the counter stage sees a quiet bus.
  always_comb begin
    slice_o = '0;
    if (state_q == RUN) begin
      slice_o = opnd_q[idx_q*CHUNK +: CHUNK];
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_popcnt_chunk_seq.sv
// tb_popcnt_chunk_seq
//   Self-checking bench for popcnt_chunk_seq. Models the external counter
//   stage combinationally and predicts results from the operand's bit count.
module tb_popcnt_chunk_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] operand;
  logic        abort;
  logic [5:0]  sliceO;
  logic [2:0]  cntI;
  logic        busy;
  logic        done;
  logic [5:0]  result;

  int vectors    = 0;
  int miscompares = 0;

  int          curExp;
  logic [35:0] curPrep;
  int          lastResult;

  popcnt_chunk_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .operand (operand),
    .abort   (abort),
    .slice_o (sliceO),
    .cnt_i   (cntI),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // Clock generation, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational counter stage.
  assign cntI = 3'($countones(sliceO));

  // Single comparison point; counts every check and reports misses.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present a start request, let it be accepted on the next edge, then
  // scramble the inputs to show later changes are ignored.
  task automatic applyStimulus(input logic [31:0] op, input logic md);
    logic [31:0] d;
    start   = 1'b1;
    operand = op;
    mode    = md;
    d       = md ? ~op : op;
    curPrep = {4'b0000, d};
    curExp  = md ? (32 - $countones(op)) : $countones(op);
    @(posedge clk); #1;
    start   = 1'b0;
    operand = $urandom;
    mode    = 1'($urandom);
  endtask

  // Follow a running count through its six slices to the done cycle.
  // Start is toggled randomly during RUN, where it must be ignored.
  task automatic runAndCheck();
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("done_run%0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("slice%0d", i), 32'(sliceO), 32'(curPrep[i*6 +: 6]));
      start = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("busy_in_done", 32'(busy), 32'd0);
    checkOutput("result", 32'(result), 32'(curExp));
    checkOutput("slice_in_done", 32'(sliceO), 32'd0);
    lastResult = curExp;
  endtask

  // Leave DONE without a new start and confirm a clean return to idle.
  task automatic checkIdleAfter();
    @(posedge clk); #1;
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("result_held", 32'(result), 32'(lastResult));
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    operand = '0;
    abort   = 1'b0;
    lastResult = 0;

    #12;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_slice", 32'(sliceO), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // All ones, count ones and count zeros.
    applyStimulus(32'hFFFFFFFF, 1'b0); runAndCheck(); checkIdleAfter();
    applyStimulus(32'hFFFFFFFF, 1'b1); runAndCheck(); checkIdleAfter();
    // Zero count of zero, sparse ones.
    applyStimulus(32'h00000000, 1'b1); runAndCheck(); checkIdleAfter();
    applyStimulus(32'h80000001, 1'b0); runAndCheck();

    // Back-to-back: start held in DONE re-enters RUN with no idle bubble.
    applyStimulus(32'h0000000F, 1'b0);
    runAndCheck(); checkIdleAfter();

    // Abort on third RUN cycle, with start asserted during RUN.
    applyStimulus(32'hFFFFFFFF, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b1;
    checkOutput("busy_before_abort", 32'(busy), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'(lastResult));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end

    // Asynchronous reset in the middle of a count.
    applyStimulus(32'hFFFFFFFF, 1'b0);
    @(posedge clk); #1;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_result", 32'(result), 32'd0);
    checkOutput("async_slice", 32'(sliceO), 32'd0);
    lastResult = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h12345678, 1'b0); runAndCheck(); checkIdleAfter();

    // Randomized counts, sometimes chained back-to-back.
    for (int n = 0; n < 24; n++) begin
      applyStimulus($urandom, 1'($urandom));
      runAndCheck();
      if ($urandom_range(0, 1) == 0) checkIdleAfter();
    end
    checkIdleAfter();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
